// File: rtl/count_pkg.sv
// Shared constants and types for the line match counter.
// Default widths, words-per-line, popcount width and FSM state enum.
package count_pkg;

  localparam int DEF_CACHE_WIDTH = 512;
  localparam int DEF_WORD_WIDTH  = 32;
  localparam int DEF_CNT_WIDTH   = 32;

  localparam int WORDS_PER_LINE =
    DEF_CACHE_WIDTH / DEF_WORD_WIDTH;

  localparam int POP_WIDTH =
    $clog2(WORDS_PER_LINE) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Bits needed to hold a count of 0..words inclusive.
  function automatic int pop_width(input int words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/match_popcount.sv
// Stages S1-S2: per-word equality mask, then registered popcount.
// Ports: clk, rst, accept, line_data, object -> s1_valid, s2_valid, pop.
module match_popcount
  import count_pkg::*;
#(
  parameter int CACHE_WIDTH = DEF_CACHE_WIDTH,
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int WPL   = CACHE_WIDTH / WORD_WIDTH,
  parameter int POP_W = pop_width(WPL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   accept,
  input  logic [CACHE_WIDTH-1:0] line_data,
  input  logic [WORD_WIDTH-1:0]  object,
  output logic                   s1_valid,
  output logic                   s2_valid,
  output logic [POP_W-1:0]       pop
);

  logic [WPL-1:0]   mask;
  logic [WPL-1:0]   mask_q;
  logic [POP_W-1:0] pop_c;

  always_comb begin
    mask = '0;
    for (int i = 0; i < WPL; i++) begin
      mask[i] =
        line_data[i*WORD_WIDTH +: WORD_WIDTH] == object;
    end
  end

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < WPL; i++) begin
      pop_c = pop_c + POP_W'(mask_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      mask_q   <= '0;
      pop      <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) mask_q <= mask;
      if (s1_valid) pop <= pop_c;
    end
  end

endmodule

// File: rtl/line_match_counter.sv
// Streaming match counter: FSM, line counter and S3 accumulator.
// Ports: clk, rst, start, object, num_lines, line_valid, line_data ->
//   line_ready, busy, done, result, line_count.
// Define LINE_MATCH_SATURATE_EN to saturate the accumulator.
module line_match_counter
  import count_pkg::*;
#(
  parameter int CACHE_WIDTH = DEF_CACHE_WIDTH,
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WORD_WIDTH-1:0]  object,
  input  logic [31:0]            num_lines,
  input  logic                   line_valid,
  input  logic [CACHE_WIDTH-1:0] line_data,
  output logic                   line_ready,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   result,
  output logic [CNT_WIDTH-1:0]   line_count
);

  localparam int WPL   = CACHE_WIDTH / WORD_WIDTH;
  localparam int POP_W = pop_width(WPL);

  state_t                state;
  logic [WORD_WIDTH-1:0] obj_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]  acc_nxt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic                  accept;
  logic                  s1_valid;
  logic                  s2_valid;
  logic [POP_W-1:0]      pop;

  assign line_ready = state == RUN;
  assign busy       = state == RUN || state == DRAIN;
  assign done       = state == DONE;
  assign result     = acc;
  assign accept     = line_ready && line_valid;
  assign cnt_nxt    = line_count + CNT_WIDTH'(1);

`ifdef LINE_MATCH_SATURATE_EN
  logic [CNT_WIDTH:0] sum;
  assign sum = {1'b0, acc} + (CNT_WIDTH+1)'(pop);
  assign acc_nxt =
    sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
`else
  assign acc_nxt = acc + CNT_WIDTH'(pop);
`endif

  match_popcount #(
    .CACHE_WIDTH (CACHE_WIDTH),
    .WORD_WIDTH  (WORD_WIDTH)
  ) u_mp (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .line_data (line_data),
    .object    (obj_q),
    .s1_valid  (s1_valid),
    .s2_valid  (s2_valid),
    .pop       (pop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      obj_q      <= '0;
      num_q      <= '0;
      acc        <= '0;
      line_count <= '0;
    end else begin
      if (s2_valid) acc <= acc_nxt;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            obj_q      <= object;
            num_q      <= CNT_WIDTH'(num_lines);
            acc        <= '0;
            line_count <= '0;
            state <= (num_lines == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (line_valid) begin
            line_count <= cnt_nxt;
            if (cnt_nxt == num_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          // S3 writes on the edge s2_valid is seen, so
          // both valids low means the last line is in.
          if (!s1_valid && !s2_valid) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_match_counter.sv
// Directed self-checking bench for line_match_counter.
// Main DUT at default widths, second DUT at CNT_WIDTH=6.
module tb_line_match_counter;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  object;
  logic [31:0]  num_lines;
  logic         line_valid;
  logic [511:0] line_data;
  logic         line_ready;
  logic         busy;
  logic         done;
  logic [31:0]  result;
  logic [31:0]  line_count;

  logic         st6;
  logic [31:0]  obj6;
  logic [31:0]  num6;
  logic         lv6;
  logic [511:0] ld6;
  logic         rdy6;
  logic         busy6;
  logic         done6;
  logic [5:0]   res6;
  logic [5:0]   cnt6;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  line_match_counter u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .object     (object),
    .num_lines  (num_lines),
    .line_valid (line_valid),
    .line_data  (line_data),
    .line_ready (line_ready),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .line_count (line_count)
  );

  line_match_counter #(.CNT_WIDTH(6)) u_dut6 (
    .clk        (clk),
    .rst        (rst),
    .start      (st6),
    .object     (obj6),
    .num_lines  (num6),
    .line_valid (lv6),
    .line_data  (ld6),
    .line_ready (rdy6),
    .busy       (busy6),
    .done       (done6),
    .result     (res6),
    .line_count (cnt6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] obj,
                    input logic [31:0] n);
    object = obj;
    num_lines = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 12 && !done; i++) tick();
    n_total++;
    if (done !== 1'b1)
      $display("FAIL %s_timeout done=%b want 1", nm, done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 0; object = 0; num_lines = 0;
    line_valid = 0; line_data = '0;
    st6 = 0; obj6 = 0; num6 = 0; lv6 = 0; ld6 = '0;
    tick(); tick();
    n_total++;
    if ({line_ready, busy, done} !== 3'b000)
      $display("FAIL rst_flags got=%b want 000",
               {line_ready, busy, done});
    else n_pass++;
    n_total++;
    if (result !== 0 || line_count !== 0)
      $display("FAIL rst_counts res=%0d cnt=%0d want 0 0",
               result, line_count);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    go(32'd5, 32'd1);
    n_total++;
    if (busy !== 1'b1 || line_ready !== 1'b1)
      $display("FAIL single_busy got=%b%b want 11",
               busy, line_ready);
    else n_pass++;
    line_data = '0;
    line_data[31:0]    = 32'd5;
    line_data[127:96]  = 32'd5;
    line_data[255:224] = 32'd5;
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    line_data = '0;
    n_total++;
    if (line_count !== 1 || line_ready !== 1'b0)
      $display("FAIL single_accept cnt=%0d rdy=%b want 1 0",
               line_count, line_ready);
    else n_pass++;
    tick(); tick();
    n_total++;
    if (done !== 1'b0)
      $display("FAIL single_early done=%b want 0", done);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b1 || result !== 3)
      $display("FAIL single_done done=%b res=%0d want 1 3",
               done, result);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] o;
    o = 32'hDEADBEEF;
    go(o, 32'd4);
    line_data = {16{o}};
    line_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (line_ready !== 1'b1)
        $display("FAIL b2b_ready%0d got=%b want 1",
                 i, line_ready);
      else n_pass++;
      tick();
    end
    n_total++;
    if (line_ready !== 1'b0 || line_count !== 4)
      $display("FAIL b2b_drain rdy=%b cnt=%0d want 0 4",
               line_ready, line_count);
    else n_pass++;
    tick();
    n_total++;
    if (line_count !== 4)
      $display("FAIL b2b_hold cnt=%0d want 4", line_count);
    else n_pass++;
    line_valid = 1'b0;
    wait_done("b2b");
    n_total++;
    if (result !== 64)
      $display("FAIL b2b_result got=%0d want 64", result);
    else n_pass++;
  endtask

  task automatic test_gaps();
    go(32'd7, 32'd3);
    for (int k = 1; k <= 3; k++) begin
      line_data = '0;
      line_data[k*64 +: 32] = 32'd7;
      line_valid = 1'b1;
      tick();
      line_valid = 1'b0;
      line_data = {16{32'd7}};
      n_total++;
      if (line_count !== k)
        $display("FAIL gap_acc%0d cnt=%0d want %0d",
                 k, line_count, k);
      else n_pass++;
      if (k < 3) begin
        tick(); tick();
        n_total++;
        if (line_count !== k)
          $display("FAIL gap_bub%0d cnt=%0d want %0d",
                   k, line_count, k);
        else n_pass++;
      end
    end
    line_data = '0;
    wait_done("gap");
    n_total++;
    if (result !== 3)
      $display("FAIL gap_result got=%0d want 3", result);
    else n_pass++;
  endtask

  task automatic test_zero();
    go(32'd9, 32'd0);
    n_total++;
    if (done !== 1'b1 || result !== 0)
      $display("FAIL zero_done done=%b res=%0d want 1 0",
               done, result);
    else n_pass++;
    n_total++;
    if (line_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_rdy rdy=%b busy=%b want 0 0",
               line_ready, busy);
    else n_pass++;
    line_data = {16{32'd9}};
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    line_data = '0;
    n_total++;
    if (line_count !== 0 || line_ready !== 1'b0)
      $display("FAIL zero_ign cnt=%0d rdy=%b want 0 0",
               line_count, line_ready);
    else n_pass++;
  endtask

  task automatic test_control();
    go(32'd1, 32'd2);
    line_data = '0;
    line_data[31:0]  = 32'd1;
    line_data[63:32] = 32'd1;
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    go(32'd0, 32'd0);
    n_total++;
    if (busy !== 1'b1 || line_count !== 1)
      $display("FAIL ctl_start busy=%b cnt=%0d want 1 1",
               busy, line_count);
    else n_pass++;
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    line_data = '0;
    wait_done("ctl");
    n_total++;
    if (result !== 4)
      $display("FAIL ctl_result got=%0d want 4", result);
    else n_pass++;
    go(32'd2, 32'd3);
    line_data = {16{32'd2}};
    line_valid = 1'b1;
    tick();
    tick();
    line_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({line_ready, busy, done} !== 3'b000 ||
        result !== 0 || line_count !== 0)
      $display("FAIL ctl_rst flags=%b res=%0d cnt=%0d want 000 0 0",
               {line_ready, busy, done}, result, line_count);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    go(32'd2, 32'd1);
    line_data = '0;
    line_data[511:480] = 32'd2;
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    line_data = '0;
    wait_done("ctl2");
    n_total++;
    if (result !== 1 || line_count !== 1)
      $display("FAIL ctl_new res=%0d cnt=%0d want 1 1",
               result, line_count);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [5:0] want;
`ifdef LINE_MATCH_SATURATE_EN
    want = 6'd63;
`else
    want = 6'd16;
`endif
    obj6 = 32'h1234_5678;
    num6 = 32'd5;
    st6 = 1'b1;
    tick();
    st6 = 1'b0;
    ld6 = {16{32'h1234_5678}};
    lv6 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    lv6 = 1'b0;
    for (int i = 0; i < 12 && !done6; i++) tick();
    n_total++;
    if (done6 !== 1'b1 || res6 !== want)
      $display("FAIL ovf_result done=%b res=%0d want 1 %0d",
               done6, res6, want);
    else n_pass++;
    n_total++;
    if (cnt6 !== 6'd5)
      $display("FAIL ovf_count got=%0d want 5", cnt6);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_zero();
    test_control();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
